// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the memory word into IF/ID, stops on HALT.
// Optional FETCH_PERF_CNT_EN adds a saturating 16-bit count of valid fetches (fetch_count).
module fetch_unit #(
  parameter int                  PC_W        = 8,
  parameter int                  INSTR_W     = 19,
  parameter int                  OPC_W       = 5,
  parameter logic [PC_W-1:0]     RESET_PC    = '0,
  parameter logic [OPC_W-1:0]    HALT_OPCODE = 5'b11111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        fetch_count,
`endif
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid,
  output logic               halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic               if_valid_q, if_valid_d;
  logic               halted_q, halted_d;
  logic               advance;

  wire [OPC_W-1:0] opcode = instruction[INSTR_W-1 -: OPC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;
    advance    = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect) pc_d = redirect_pc;
      end
      RUN: begin
        if (redirect) begin
          // The word at the old pc is squashed, even if it is a HALT.
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          advance    = 1'b1;
          if_instr_d = instruction;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (opcode == HALT_OPCODE) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      HALTED: begin
        if (redirect) begin
          state_d    = RUN;
          halted_d   = 1'b0;
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_valid_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count_q <= '0;
    else if (advance && fetch_count_q != 16'hFFFF)
      fetch_count_q <= fetch_count_q + 16'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

  assign pc       = pc_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: combinational instruction memory model plus a queue of expected
// {word, pc} fetches popped at each normal-advance edge.
module tb_fetch_unit;

  localparam logic [18:0] HALT_WORD = {5'b11111, 14'h0005};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [18:0] instruction;
  logic [7:0]  pc;
  logic [18:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  logic [18:0] mem [256];
  logic [26:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  assign instruction = mem[pc];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .pc          (pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
`endif
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input logic s, input logic r, input logic [7:0] rp);
    stall = s;
    redirect = r;
    redirect_pc = rp;
    @(posedge clk);
    #1;
    stall = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] addr);
    exp_q.push_back({mem[addr], addr});
  endtask

  // One normal-advance edge; the DUT must present the oldest queued fetch.
  task automatic advance(input string tag);
    logic [26:0] e;
    tick(1'b0, 1'b0, 8'h00);
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, " if_valid"}, 32'(if_valid), 32'd1);
      check({tag, " if_instr"}, 32'(if_instr), 32'(e[26:8]));
      check({tag, " if_pc"},    32'(if_pc),    32'(e[7:0]));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 19'(i + 1);
    mem[5] = HALT_WORD;

    #2;
    check("reset pc", 32'(pc), 32'h0);
    check("reset if_valid", 32'(if_valid), 32'h0);
    check("reset if_instr", 32'(if_instr), 32'h0);
    check("reset halted", 32'(halted), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // BOOT cycle: no fetch, pc held
    tick(1'b0, 1'b0, 8'h00);
    check("boot if_valid", 32'(if_valid), 32'h0);
    check("boot pc", 32'(pc), 32'h0);

    push_exp(8'd0); push_exp(8'd1);
    advance("seq0");
    advance("seq1");
    check("seq pc", 32'(pc), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 8'h00);
      check("stall pc", 32'(pc), 32'h2);
      check("stall if_instr", 32'(if_instr), 32'h2);
      check("stall if_valid", 32'(if_valid), 32'h1);
    end
    push_exp(8'd2); push_exp(8'd3);
    advance("seq2");
    advance("seq3");
`ifdef FETCH_PERF_CNT_EN
    check("count after 4", 32'(fetch_count), 32'd4);
`endif

    // HALT at address 5, then stall keeps it presented, then it drops
    push_exp(8'd4); push_exp(8'd5);
    advance("pre_halt");
    advance("halt");
    check("halt pc", 32'(pc), 32'h5);
    check("halt flag", 32'(halted), 32'h1);
    tick(1'b1, 1'b0, 8'h00);
    check("halt stall if_valid", 32'(if_valid), 32'h1);
    check("halt stall if_instr", 32'(if_instr), 32'(HALT_WORD));
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      check("halted if_valid", 32'(if_valid), 32'h0);
      check("halted pc", 32'(pc), 32'h5);
      check("halted flag", 32'(halted), 32'h1);
    end
    tick(1'b0, 1'b1, 8'h10);
    check("unhalt flag", 32'(halted), 32'h0);
    check("unhalt pc", 32'(pc), 32'h10);
    check("unhalt if_valid", 32'(if_valid), 32'h0);
    push_exp(8'h10);
    advance("resume");

    // redirect wins over stall
    tick(1'b1, 1'b1, 8'h40);
    check("redir pc", 32'(pc), 32'h40);
    check("redir if_valid", 32'(if_valid), 32'h0);
    push_exp(8'h40);
    advance("redir_fetch");

    // a HALT word squashed by redirect never halts
    tick(1'b0, 1'b1, 8'h05);
    tick(1'b0, 1'b1, 8'h20);
    check("squash halted", 32'(halted), 32'h0);
    check("squash pc", 32'(pc), 32'h20);
    check("squash if_valid", 32'(if_valid), 32'h0);

    // pc wrap
    tick(1'b0, 1'b1, 8'hFE);
    push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00); push_exp(8'h01);
    for (int i = 0; i < 4; i++) advance("wrap");
    check("wrap pc", 32'(pc), 32'h2);

    // asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check("async pc", 32'(pc), 32'h0);
    check("async if_valid", 32'(if_valid), 32'h0);
    check("async halted", 32'(halted), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("async count", 32'(fetch_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // redirect honoured during BOOT
    tick(1'b0, 1'b1, 8'h30);
    check("boot redir pc", 32'(pc), 32'h30);
    check("boot redir if_valid", 32'(if_valid), 32'h0);
    push_exp(8'h30);
    advance("boot_redir_fetch");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
